// File: rtl/shift_deser.sv
// shift_deser: LSB-first serial-in/parallel-out receiver with a one-entry
// valid/ready output buffer and a sticky overrun flag for dropped words.
module shift_deser #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       sin,
   input  logic                       sync,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt,
   output logic                       overrun
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;

   // Only the upper WIDTH-1 bits of the shifter are ever needed: the bit
   // that would fall into position 0 is replaced by sin on completion.
   logic [WIDTH-1:1] sr;
   logic [WIDTH-1:0] word;
   logic             complete;

   // Word as it stands including this cycle's bit, and completion detect
   assign word     = {sin, sr};
   assign complete = en && !sync && (bit_cnt == LAST_BIT);

   // Shifter, bit counter, output buffer FSM and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         sr         <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         state      <= EMPTY;
      end else begin
         if (sync) begin
            sr      <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
         end else if (en) begin
            sr      <= word[WIDTH-1:1];
            bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
         end

         case (state)
            EMPTY: begin
               if (complete) begin
                  dout       <= word;
                  dout_valid <= 1'b1;
                  state      <= FULL;
               end
            end
            FULL: begin
               if (complete) begin
                  if (dout_ready) begin
                     dout <= word;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (dout_ready) begin
                  dout_valid <= 1'b0;
                  state      <= EMPTY;
               end
            end
            default: begin
               dout_valid <= 1'b0;
               state      <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed stimulus with a scoreboard queue of expected
// words; a monitor pops and compares on every output handshake.
module tb_shift_deser;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         sin = 1'b0;
   logic         sync = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic [2:0]   bit_cnt;
   logic         overrun;

   int           n_checks = 0;
   int           n_pass = 0;
   logic [W-1:0] sb[$];

   shift_deser #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sin        (sin),
      .sync       (sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs read there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send a word LSB-first with 'gap' idle cycles after every bit but the last
   task automatic send_word(input logic [W-1:0] w, input int gap, input bit chk_gap);
      for (int i = 0; i < int'(W); i++) begin
         en  = 1'b1;
         sin = w[i];
         tick();
         en  = 1'b0;
         if (i != int'(W) - 1) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               if (chk_gap) check("gap_bit_cnt", 32'(bit_cnt), 32'(i + 1));
            end
         end
      end
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         en  = 1'b1;
         sin = w[i];
         tick();
      end
      en = 1'b0;
   endtask

   // Monitor: a handshake is what the next rising edge will sample
   always @(negedge clk) begin
      if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL mon_unexpected: got word 0x%0h, expected no word", dout);
         end else begin
            check("mon_dout", 32'(dout), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // T1 reset
      rst = 1'b1;
      tick();
      tick();
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b0;

      // T2 basic word with ready high
      dout_ready = 1'b1;
      send_bits(8'hA5, 7);
      check("t2_bit_cnt7", 32'(bit_cnt), 32'h7);
      check("t2_valid_early", 32'(dout_valid), 32'h0);
      sb.push_back(8'hA5);
      en = 1'b1;
      sin = 1'b1;
      tick();
      en = 1'b0;
      check("t2_valid", 32'(dout_valid), 32'h1);
      check("t2_dout", 32'(dout), 32'hA5);
      check("t2_bit_cnt0", 32'(bit_cnt), 32'h0);

      // T3 gaps of 3 idle cycles between bits
      sb.push_back(8'h3C);
      send_word(8'h3C, 3, 1'b1);
      check("t3_valid", 32'(dout_valid), 32'h1);
      check("t3_dout", 32'(dout), 32'h3C);
      tick();
      check("t3_drained", 32'(dout_valid), 32'h0);

      // T4 backpressure: second word dropped
      dout_ready = 1'b0;
      sb.push_back(8'h11);
      send_word(8'h11, 0, 1'b0);
      check("t4_valid1", 32'(dout_valid), 32'h1);
      check("t4_dout1", 32'(dout), 32'h11);
      check("t4_ovr0", 32'(overrun), 32'h0);
      send_word(8'h22, 0, 1'b0);
      check("t4_dout_held", 32'(dout), 32'h11);
      check("t4_ovr1", 32'(overrun), 32'h1);
      dout_ready = 1'b1;
      tick();
      check("t4_drained", 32'(dout_valid), 32'h0);
      check("t4_ovr_sticky", 32'(overrun), 32'h1);

      // Sync with no partial word clears the sticky flag
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("sync_ovr_clr", 32'(overrun), 32'h0);

      // T5 drain and complete in the same cycle
      dout_ready = 1'b0;
      sb.push_back(8'h11);
      send_word(8'h11, 0, 1'b0);
      send_bits(8'h22, 7);
      check("t5_held", 32'(dout), 32'h11);
      dout_ready = 1'b1;
      sb.push_back(8'h22);
      en = 1'b1;
      sin = 1'b0;
      tick();
      en = 1'b0;
      check("t5_dout", 32'(dout), 32'h22);
      check("t5_valid", 32'(dout_valid), 32'h1);
      check("t5_ovr", 32'(overrun), 32'h0);
      tick();

      // T6a resync mid-word
      send_bits(8'h07, 3);
      check("t6_bit_cnt3", 32'(bit_cnt), 32'h3);
      sync = 1'b1;
      en = 1'b1;
      sin = 1'b1;
      tick();
      sync = 1'b0;
      en = 1'b0;
      check("t6_sync_cnt", 32'(bit_cnt), 32'h0);
      sb.push_back(8'h5A);
      send_word(8'h5A, 0, 1'b0);
      check("t6_dout_sync", 32'(dout), 32'h5A);
      tick();

      // T6b reset mid-word while a word is held
      dout_ready = 1'b0;
      send_word(8'h77, 0, 1'b0);
      check("t6_held77", 32'(dout), 32'h77);
      send_bits(8'h07, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", 32'(dout_valid), 32'h0);
      check("t6_rst_dout", 32'(dout), 32'h0);
      check("t6_rst_cnt", 32'(bit_cnt), 32'h0);
      dout_ready = 1'b1;
      sb.push_back(8'h5A);
      send_word(8'h5A, 0, 1'b0);
      check("t6_dout_rst", 32'(dout), 32'h5A);
      check("t6_valid_rst", 32'(dout_valid), 32'h1);
      tick();
      tick();
      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
